// File: rtl/pattern_sequencer_16b_pkg.sv
// rtl/pattern_sequencer_16b_pkg.sv - shared types and constants for the pattern sequencer
//
// Purpose: source-select and FSM enums, PRBS-15 seed and tap positions, and the
//          LFSR next-state helper used by prbs15_gen.
// Ports:   none (package).

package pattern_seq_pkg;

  typedef enum logic [1:0] {
    MODE_CNT  = 2'd0,
    MODE_PRBS = 2'd1,
    MODE_LIST = 2'd2
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_INIT_CLR = 3'd1,
    ST_RUN      = 3'd2,
    ST_MID_CLR  = 3'd3,
    ST_DONE     = 3'd4
  } state_e;

  localparam logic [14:0] PRBS_SEED  = 15'h0001;
  localparam int          PRBS_TAP_A = 13;
  localparam int          PRBS_TAP_B = 14;

  // x^15 + x^14 + 1: shift left, feed back x13 ^ x14 into bit 0.
  function automatic logic [14:0] prbs15_next(input logic [14:0] x);
    return {x[13:0], x[PRBS_TAP_A] ^ x[PRBS_TAP_B]};
  endfunction

endpackage

// File: rtl/pattern_sequencer_16b_if.sv
// rtl/pattern_sequencer_16b_if.sv - control and operand bus of the pattern sequencer
//
// Purpose: bundles run control, list loading and the stimulus outputs.
// Signals: start, mode[1:0], num_vec, clr_cycle, load_we, load_data[15:0]  (master -> slave)
//          data_out[15:0], data_valid, dut_clear, busy, done, vec_cnt,
//          list_cnt, exp_sum[15:0]                                        (slave -> master)
// Modports: master (bench / controller), slave (sequencer).

interface pattern_sequencer_16b_if #(
  parameter int DEPTH = 16,
  parameter int VEC_W = 16
);
  localparam int LW = $clog2(DEPTH + 1);

  logic             start;
  logic [1:0]       mode;
  logic [VEC_W-1:0] num_vec;
  logic [VEC_W-1:0] clr_cycle;
  logic             load_we;
  logic [15:0]      load_data;

  logic [15:0]      data_out;
  logic             data_valid;
  logic             dut_clear;
  logic             busy;
  logic             done;
  logic [VEC_W-1:0] vec_cnt;
  logic [LW-1:0]    list_cnt;
  logic [15:0]      exp_sum;

  modport master (
    output start, mode, num_vec, clr_cycle, load_we, load_data,
    input  data_out, data_valid, dut_clear, busy, done, vec_cnt, list_cnt, exp_sum
  );

  modport slave (
    input  start, mode, num_vec, clr_cycle, load_we, load_data,
    output data_out, data_valid, dut_clear, busy, done, vec_cnt, list_cnt, exp_sum
  );

endinterface

// File: rtl/pattern_sequencer_16b_prbs15_gen.sv
// rtl/pattern_sequencer_16b_prbs15_gen.sv - PRBS-15 LFSR source
//
// Purpose: 15-bit Fibonacci LFSR (x^15 + x^14 + 1), reseeded to PRBS_SEED on demand.
// Ports:   i_clk        clock
//          i_rst        synchronous active-high reset (loads seed)
//          i_seed_load  reload seed (start of a run)
//          i_en         advance one step
//          o_state      current LFSR state x[14:0]

module prbs15_gen
  import pattern_seq_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_seed_load,
  input  logic        i_en,
  output logic [14:0] o_state
);

  logic [14:0] r_lfsr;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_seed_load) begin
      r_lfsr <= PRBS_SEED;
    end else if (i_en) begin
      r_lfsr <= prbs15_next(r_lfsr);
    end
  end

  assign o_state = r_lfsr;

endmodule

// File: rtl/pattern_sequencer_16b.sv
// rtl/pattern_sequencer_16b.sv - 16-bit stimulus sequencer (counter / PRBS-15 / data list)
//
// Purpose: runs one test sequence: initial DUT clear, num_vec vectors from the
//          selected source, optional mid-run clear, one-cycle done pulse.
// Ports:   CLK    system clock
//          CLEAR  synchronous active-high reset
//          bus    pattern_sequencer_16b_if.slave (run control, list load, outputs)
// Build option: PATSEQ_CHECK_EN builds the expected-sum accumulator on exp_sum;
//               otherwise exp_sum is tied to 0.

module pattern_sequencer_16b #(
  parameter int DEPTH = 16,
  parameter int VEC_W = 16
) (
  input  logic                    CLK,
  input  logic                    CLEAR,
  pattern_sequencer_16b_if.slave  bus
);
  import pattern_seq_pkg::*;

  localparam int LW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e           r_state;
  logic [1:0]       r_mode;
  logic [VEC_W-1:0] r_num_vec;
  logic [VEC_W-1:0] r_clr_cycle;
  logic [VEC_W-1:0] r_vec_cnt;
  logic [15:0]      r_cnt;
  logic [LW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_list_cnt;
  logic [15:0]      r_list [DEPTH];
  logic [15:0]      r_data_out;
  logic             r_data_valid;
  logic             r_dut_clear;
  logic             r_busy;
  logic             r_done;

  logic             w_load_ok;
  logic             w_seed_load;
  logic             w_run_end;
  logic             w_run_clr;
  logic             w_emit;
  logic             w_list_hit;
  logic             w_prbs_en;
  logic [14:0]      w_prbs;
  logic [15:0]      w_list_data;
  logic [15:0]      w_src_data;

  // Loads only land in IDLE; a load coincident with start is counted before
  // the run begins reading, so the run sees that entry.
  assign w_load_ok   = (r_state == ST_IDLE) && bus.load_we && (r_list_cnt < LW'(DEPTH));
  assign w_seed_load = (r_state == ST_IDLE) && bus.start;

  // r_vec_cnt already counts the vector on data_out this cycle.
  assign w_run_end = (r_vec_cnt == r_num_vec);
  assign w_run_clr = (r_clr_cycle != '0) && (r_vec_cnt == r_clr_cycle);

  // w_emit: the coming edge puts a new vector on data_out and steps its source.
  always_comb begin
    w_emit = 1'b0;
    case (r_state)
      ST_INIT_CLR: w_emit = (r_num_vec != '0);
      ST_RUN:      w_emit = !w_run_end && !w_run_clr;
      ST_MID_CLR:  w_emit = 1'b1;
      default:     w_emit = 1'b0;
    endcase
  end

  assign w_list_hit  = (r_rd_ptr < r_list_cnt);
  assign w_list_data = w_list_hit ? r_list[r_rd_ptr[IW-1:0]] : 16'h0000;

  always_comb begin
    w_src_data = w_list_data;
    if (r_mode == MODE_CNT) begin
      w_src_data = r_cnt;
    end else if (r_mode == MODE_PRBS) begin
      w_src_data = {1'b0, w_prbs};
    end
  end

  assign w_prbs_en = w_emit && (r_mode == MODE_PRBS);

  prbs15_gen u_prbs (
    .i_clk       (CLK),
    .i_rst       (CLEAR),
    .i_seed_load (w_seed_load),
    .i_en        (w_prbs_en),
    .o_state     (w_prbs)
  );

  // List storage is not reset; list_cnt alone defines which entries are live.
  always_ff @(posedge CLK) begin
    if (w_load_ok) begin
      r_list[r_list_cnt[IW-1:0]] <= bus.load_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (CLEAR) begin
      r_state      <= ST_IDLE;
      r_mode       <= 2'd0;
      r_num_vec    <= '0;
      r_clr_cycle  <= '0;
      r_vec_cnt    <= '0;
      r_cnt        <= 16'h0000;
      r_rd_ptr     <= '0;
      r_list_cnt   <= '0;
      r_data_out   <= 16'h0000;
      r_data_valid <= 1'b0;
      r_dut_clear  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      if (w_load_ok) begin
        r_list_cnt <= r_list_cnt + LW'(1);
      end

      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_mode      <= bus.mode;
            r_num_vec   <= bus.num_vec;
            r_clr_cycle <= bus.clr_cycle;
            r_cnt       <= 16'h0000;
            r_rd_ptr    <= '0;
            r_vec_cnt   <= '0;
            r_dut_clear <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= ST_INIT_CLR;
          end
        end

        ST_INIT_CLR: begin
          r_dut_clear <= 1'b0;
          if (r_num_vec == '0) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_state <= ST_RUN;
          end
        end

        ST_RUN: begin
          // End of run takes priority over a clear scheduled on the last vector.
          if (w_run_end) begin
            r_data_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b1;
            r_state      <= ST_DONE;
          end else if (w_run_clr) begin
            r_data_valid <= 1'b0;
            r_dut_clear  <= 1'b1;
            r_state      <= ST_MID_CLR;
          end
        end

        ST_MID_CLR: begin
          r_dut_clear <= 1'b0;
          r_state     <= ST_RUN;
        end

        ST_DONE: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end

        default: r_state <= ST_IDLE;
      endcase

      if (w_emit) begin
        r_data_out   <= w_src_data;
        r_data_valid <= 1'b1;
        r_vec_cnt    <= r_vec_cnt + VEC_W'(1);
        if (r_mode == MODE_CNT) begin
          r_cnt <= r_cnt + 16'd1;
        end
        if (r_mode[1] && w_list_hit) begin
          r_rd_ptr <= r_rd_ptr + LW'(1);
        end
      end
    end
  end

`ifdef PATSEQ_CHECK_EN
  logic [15:0] r_exp_sum;

  // Mirrors the DUT accumulator: cleared with dut_clear, adds each valid vector.
  always_ff @(posedge CLK) begin
    if (CLEAR || r_dut_clear) begin
      r_exp_sum <= 16'h0000;
    end else if (r_data_valid) begin
      r_exp_sum <= r_exp_sum + r_data_out;
    end
  end

  assign bus.exp_sum = r_exp_sum;
`else
  assign bus.exp_sum = 16'h0000;
`endif

  assign bus.data_out   = r_data_out;
  assign bus.data_valid = r_data_valid;
  assign bus.dut_clear  = r_dut_clear;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.vec_cnt    = r_vec_cnt;
  assign bus.list_cnt   = r_list_cnt;

endmodule
